// File: rtl/system_qsys_nios2_oci_dct_packer_pkg.sv
// Shared constants and frame type for the DCT trace symbol packer.
package system_qsys_nios2_oci_dct_packer_pkg;

  localparam int SLOTS   = 15;
  localparam int SYM_W   = 2;
  localparam int FRAME_W = SLOTS * SYM_W;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [FRAME_W-1:0] buffer;
    logic [CNT_W-1:0]   count;
  } frame_t;

  localparam frame_t FRAME_EMPTY = '{buffer: '0, count: '0};

endpackage

// File: rtl/system_qsys_nios2_oci_dct_acc.sv
// Symbol accumulator: writes accepted symbols into consecutive slots and
// exposes the post-accept contents so a frame can launch in the same cycle.
module system_qsys_nios2_oci_dct_acc
  import system_qsys_nios2_oci_dct_packer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   sym_data,
  input  logic               clear,
  output logic               sym_ready,
  output logic [CNT_W-1:0]   next_cnt,
  output logic [FRAME_W-1:0] next_buf
);

  logic [CNT_W-1:0]   acc_cnt_reg;
  logic [FRAME_W-1:0] acc_buf_reg;
  logic               accept;

  assign sym_ready = (acc_cnt_reg < CNT_W'(SLOTS));
  assign accept    = sym_valid & sym_ready;
  assign next_cnt  = acc_cnt_reg + CNT_W'(accept);

  // Only the slot addressed by the current count takes the new symbol.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign next_buf[gi*SYM_W +: SYM_W] =
      (accept && (acc_cnt_reg == CNT_W'(gi))) ? sym_data
                                              : acc_buf_reg[gi*SYM_W +: SYM_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      acc_cnt_reg <= '0;
      acc_buf_reg <= '0;
    end else begin
      acc_cnt_reg <= next_cnt;
      acc_buf_reg <= next_buf;
    end
  end

endmodule

// File: rtl/system_qsys_nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols into 15-slot frames with a single output hold
// register; frames launch when full or on flush.
module system_qsys_nios2_oci_dct_packer
  import system_qsys_nios2_oci_dct_packer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sym_valid,
  input  logic [SYM_W-1:0]   sym_data,
  output logic               sym_ready,
  input  logic               flush,
  output logic [FRAME_W-1:0] dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               dct_valid,
  input  logic               dct_ready,
  output logic [15:0]        frames_sent
);

  frame_t             hold_reg;
  logic               dct_valid_reg;
  logic               flush_pend_reg;
  logic [15:0]        frames_sent_reg;
  logic [CNT_W-1:0]   next_cnt;
  logic [FRAME_W-1:0] next_buf;
  logic               out_free;
  logic               launch;
  logic               flush_any;

  system_qsys_nios2_oci_dct_acc u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .clear     (launch),
    .sym_ready (sym_ready),
    .next_cnt  (next_cnt),
    .next_buf  (next_buf)
  );

  assign out_free  = !dct_valid_reg | dct_ready;
  assign flush_any = flush | flush_pend_reg;
  assign launch    = out_free &
                     ((next_cnt == CNT_W'(SLOTS)) | (flush_any & (next_cnt != '0)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_reg        <= FRAME_EMPTY;
      dct_valid_reg   <= 1'b0;
      flush_pend_reg  <= 1'b0;
      frames_sent_reg <= '0;
    end else begin
      if (launch) begin
        hold_reg        <= '{buffer: next_buf, count: next_cnt};
        dct_valid_reg   <= 1'b1;
        frames_sent_reg <= frames_sent_reg + 16'd1;
      end else if (dct_valid_reg && dct_ready) begin
        hold_reg      <= FRAME_EMPTY;
        dct_valid_reg <= 1'b0;
      end
      // A flush with nothing to send is dropped rather than armed.
      if (launch)
        flush_pend_reg <= 1'b0;
      else if (flush && (next_cnt != '0))
        flush_pend_reg <= 1'b1;
    end
  end

  assign dct_buffer  = hold_reg.buffer;
  assign dct_count   = hold_reg.count;
  assign dct_valid   = dct_valid_reg;
  assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_system_qsys_nios2_oci_dct_packer.sv
// Directed bench for the DCT packer with hand-computed expected frames.
module tb_system_qsys_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic [15:0] frames_sent;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  system_qsys_nios2_oci_dct_packer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .sym_ready   (sym_ready),
    .flush       (flush),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .dct_valid   (dct_valid),
    .dct_ready   (dct_ready),
    .frames_sent (frames_sent)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                           input logic [29:0] b, input logic [15:0] f);
    check({tag, ".valid"},  32'(dct_valid),   32'(v));
    check({tag, ".count"},  32'(dct_count),   32'(c));
    check({tag, ".buffer"}, 32'(dct_buffer),  32'(b));
    check({tag, ".frames"}, 32'(frames_sent), 32'(f));
    $display("[TB] %s: valid=%0d count=%0d buffer=0x%08h frames=%0d sym_ready=%0d",
             tag, dct_valid, dct_count, dct_buffer, frames_sent, sym_ready);
  endtask

  initial begin
    reset_n = 1'b0; sym_valid = 1'b0; sym_data = 2'd0; flush = 1'b0; dct_ready = 1'b0;
    step(); step();
    check_out("reset", 1'b0, 4'd0, 30'h0, 16'd0);
    check("reset.sym_ready", 32'(sym_ready), 32'd1);

    // Full frame 0,1,2,3,... with consumer ready
    reset_n = 1'b1; dct_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      sym_valid = 1'b1; sym_data = 2'(i % 4);
      step();
      if (i == 13) check("full.before_last", 32'(dct_valid), 32'd0);
    end
    sym_valid = 1'b0;
    check_out("full", 1'b1, 4'd15, 30'h24E4E4E4, 16'd1);
    check("full.sym_ready", 32'(sym_ready), 32'd1);
    step();
    check_out("full.drain", 1'b0, 4'd0, 30'h0, 16'd1);

    // Three symbols with flush on the third
    sym_valid = 1'b1; sym_data = 2'd3; step();
    sym_data = 2'd2; step();
    sym_data = 2'd1; flush = 1'b1; step();
    sym_valid = 1'b0; flush = 1'b0;
    check_out("flush3", 1'b1, 4'd3, 30'h1B, 16'd2);
    step();
    check_out("flush3.drain", 1'b0, 4'd0, 30'h0, 16'd2);

    // Flush on empty accumulator is discarded
    flush = 1'b1; step();
    flush = 1'b0;
    check_out("flush_empty", 1'b0, 4'd0, 30'h0, 16'd2);
    sym_valid = 1'b1; sym_data = 2'd2; step();
    sym_valid = 1'b0; step();
    check_out("no_autolaunch", 1'b0, 4'd0, 30'h0, 16'd2);
    flush = 1'b1; step();
    flush = 1'b0;
    check_out("late_flush", 1'b1, 4'd1, 30'h2, 16'd3);
    step();

    // Backpressure: hold one frame, keep streaming
    dct_ready = 1'b0;
    sym_valid = 1'b1; sym_data = 2'd1;
    for (int i = 0; i < 15; i++) step();
    check_out("bp.held", 1'b1, 4'd15, 30'h15555555, 16'd4);
    sym_data = 2'd2;
    for (int i = 0; i < 20; i++) step();
    check_out("bp.stable", 1'b1, 4'd15, 30'h15555555, 16'd4);
    check("bp.sym_ready", 32'(sym_ready), 32'd0);
    dct_ready = 1'b1; step();
    sym_valid = 1'b0;
    check_out("bp.release", 1'b1, 4'd15, 30'h2AAAAAAA, 16'd5);
    check("bp.sym_ready_after", 32'(sym_ready), 32'd1);
    step();
    check_out("bp.drain", 1'b0, 4'd0, 30'h0, 16'd5);

    // Reset with partial accumulator and a held frame
    dct_ready = 1'b0;
    sym_valid = 1'b1; sym_data = 2'd3; flush = 1'b1; step();
    flush = 1'b0; sym_data = 2'd1;
    for (int i = 0; i < 7; i++) step();
    sym_valid = 1'b0;
    check_out("pre_reset", 1'b1, 4'd1, 30'h3, 16'd6);
    reset_n = 1'b0; step();
    check_out("mid_reset", 1'b0, 4'd0, 30'h0, 16'd0);
    check("mid_reset.sym_ready", 32'(sym_ready), 32'd1);
    reset_n = 1'b1; dct_ready = 1'b1; step(); step();
    check_out("post_reset", 1'b0, 4'd0, 30'h0, 16'd0);

    // frames_sent wrap: one single-symbol frame per cycle
    sym_valid = 1'b1; sym_data = 2'd1; flush = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    check_out("wrap.ffff", 1'b1, 4'd1, 30'h1, 16'hFFFF);
    step();
    sym_valid = 1'b0; flush = 1'b0;
    check_out("wrap.0000", 1'b1, 4'd1, 30'h1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
